load_store_unit: RTL and testbench

Bus initiator that turns CPU load/store micro-ops into single-beat transactions on the data bus (request/address/write/wstrb/wdata/rdata/ack) that the instruction memory and other responders serve. It sits between the execute stage and the data bus. It generates byte strobes and replicated write data, checks alignment, waits for the responder's ack, and returns sign- or zero-extended load data. One transaction is outstanding at a time.

---
 rtl/load_store_unit.sv | 197 +++++++++++++++++++
 tb/tb_load_store_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
//
// Converts CPU load/store micro-ops into single-beat data-bus transactions.
// One transaction is in flight at a time. Byte strobes and lane-replicated
// write data are generated, alignment and size legality are checked, and load
// data is returned sign- or zero-extended. Every output is driven directly from
// a flop, so no combinational path runs from ack/rdata to any output.
//
// Optional feature macro: LSU_TIMEOUT_EN
//   defined   : WAIT aborts with cpu_error after TIMEOUT cycles without ack
//   undefined : WAIT persists until ack or reset
//
// Parameters
//   ADDR_WIDTH  byte address width on the bus (>= 2)
//   TIMEOUT     ack wait limit in cycles (used only with LSU_TIMEOUT_EN)
//
// Ports
//   clock, reset          rising-edge clock, synchronous active-high reset
//   cpu_valid/cpu_write/cpu_size/cpu_unsigned/cpu_addr/cpu_wdata
//                         op from execute stage; accepted only when not busy
//   cpu_busy              op in flight (REQ, WAIT, DONE)
//   cpu_done              one-cycle completion pulse
//   cpu_error             with cpu_done: misaligned, illegal size or timeout
//   cpu_rdata             with cpu_done: extended load data (0 for stores)
//   request               bus request, one cycle per transaction
//   address/write/wstrb/wdata  bus command, held from REQ through DONE
//   rdata, ack            responder data and completion
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int ADDR_WIDTH = 32,
    parameter int TIMEOUT    = 256
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cpu_valid,
    input  logic                  cpu_write,
    input  logic [1:0]            cpu_size,
    input  logic                  cpu_unsigned,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [31:0]           cpu_wdata,
    output logic                  cpu_busy,
    output logic                  cpu_done,
    output logic                  cpu_error,
    output logic [31:0]           cpu_rdata,
    output logic                  request,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  write,
    output logic [3:0]            wstrb,
    output logic [31:0]           wdata,
    input  logic [31:0]           rdata,
    input  logic                  ack
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;

    state_t      state_reg;
    logic [1:0]  size_reg;
    logic [1:0]  offset_reg;
    logic        unsigned_reg;

    logic        legal_next;
    logic [3:0]  strb_next;
    logic [31:0] wdata_next;
    logic [31:0] lane_data;
    logic [31:0] load_next;

    // Half needs addr[0]=0, word needs addr[1:0]=00, size 11 is never legal.
    assign legal_next = (cpu_size == SIZE_BYTE) ||
                        (cpu_size == SIZE_HALF && !cpu_addr[0]) ||
                        (cpu_size == SIZE_WORD && cpu_addr[1:0] == 2'b00);

    // Per-lane strobe and write-data replication from the incoming op.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign strb_next[gi] = (cpu_size == SIZE_BYTE) ? (cpu_addr[1:0] == LANE) :
                                   (cpu_size == SIZE_HALF) ? (cpu_addr[1] == LANE[1]) :
                                   1'b1;

            assign wdata_next[8*gi +: 8] = (cpu_size == SIZE_BYTE) ? cpu_wdata[7:0] :
                                           (cpu_size == SIZE_HALF) ? cpu_wdata[8*(gi%2) +: 8] :
                                           cpu_wdata[8*gi +: 8];
        end
    endgenerate

    // Only legal ops reach the bus, so a half is at offset 0 or 2 and a shift
    // of 8*offset covers both the byte and the half lane rules.
    assign lane_data = rdata >> {offset_reg, 3'b000};

    always_comb begin
        load_next = lane_data;
        case (size_reg)
            SIZE_BYTE: load_next = {{24{!unsigned_reg & lane_data[7]}},  lane_data[7:0]};
            SIZE_HALF: load_next = {{16{!unsigned_reg & lane_data[15]}}, lane_data[15:0]};
            default:   load_next = lane_data;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
    logic [CNT_W-1:0] wait_cnt_reg;
`else
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg    <= IDLE;
            size_reg     <= 2'b00;
            offset_reg   <= 2'b00;
            unsigned_reg <= 1'b0;
            cpu_busy     <= 1'b0;
            cpu_done     <= 1'b0;
            cpu_error    <= 1'b0;
            cpu_rdata    <= 32'h0;
            request      <= 1'b0;
            address      <= '0;
            write        <= 1'b0;
            wstrb        <= 4'h0;
            wdata        <= 32'h0;
`ifdef LSU_TIMEOUT_EN
            wait_cnt_reg <= '0;
`endif
        end else begin
            request  <= 1'b0;
            cpu_done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (cpu_valid) begin
                        size_reg     <= cpu_size;
                        offset_reg   <= cpu_addr[1:0];
                        unsigned_reg <= cpu_unsigned;
                        cpu_busy     <= 1'b1;
                        if (legal_next) begin
                            state_reg <= REQ;
                            request   <= 1'b1;
                            address   <= cpu_addr;
                            write     <= cpu_write;
                            wstrb     <= cpu_write ? strb_next : 4'h0;
                            wdata     <= wdata_next;
                        end else begin
                            // Rejected without touching the bus.
                            state_reg <= DONE;
                            cpu_done  <= 1'b1;
                            cpu_error <= 1'b1;
                            cpu_rdata <= 32'h0;
                        end
                    end
                end
                REQ: begin
                    state_reg <= WAIT;
`ifdef LSU_TIMEOUT_EN
                    wait_cnt_reg <= '0;
`endif
                end
                WAIT: begin
                    if (ack) begin
                        state_reg <= DONE;
                        cpu_done  <= 1'b1;
                        cpu_error <= 1'b0;
                        cpu_rdata <= write ? 32'h0 : load_next;
                    end
`ifdef LSU_TIMEOUT_EN
                    else if (wait_cnt_reg == CNT_W'(TIMEOUT - 1)) begin
                        state_reg <= DONE;
                        cpu_done  <= 1'b1;
                        cpu_error <= 1'b1;
                        cpu_rdata <= 32'h0;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + 1'b1;
                    end
`endif
                end
                DONE: begin
                    // Bus command was held through this cycle; drop it now.
                    state_reg <= IDLE;
                    cpu_busy  <= 1'b0;
                    cpu_error <= 1'b0;
                    cpu_rdata <= 32'h0;
                    address   <= '0;
                    write     <= 1'b0;
                    wstrb     <= 4'h0;
                    wdata     <= 32'h0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// Testbench for load_store_unit: directed cases followed by randomized ops,
// each checked against an arithmetic reference model of strobes, replicated
// write data and load extension. The bench acts as the bus responder.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

    logic        clock;
    logic        reset;
    logic        cpu_valid;
    logic        cpu_write;
    logic [1:0]  cpu_size;
    logic        cpu_unsigned;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_wdata;
    logic        cpu_busy;
    logic        cpu_done;
    logic        cpu_error;
    logic [31:0] cpu_rdata;
    logic        request;
    logic [31:0] address;
    logic        write;
    logic [3:0]  wstrb;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        ack;

    int total = 0;
    int bad   = 0;
    int req_count  = 0;
    int done_count = 0;

    load_store_unit #(.ADDR_WIDTH(32), .TIMEOUT(256)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_valid    (cpu_valid),
        .cpu_write    (cpu_write),
        .cpu_size     (cpu_size),
        .cpu_unsigned (cpu_unsigned),
        .cpu_addr     (cpu_addr),
        .cpu_wdata    (cpu_wdata),
        .cpu_busy     (cpu_busy),
        .cpu_done     (cpu_done),
        .cpu_error    (cpu_error),
        .cpu_rdata    (cpu_rdata),
        .request      (request),
        .address      (address),
        .write        (write),
        .wstrb        (wstrb),
        .wdata        (wdata),
        .rdata        (rdata),
        .ack          (ack)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Count request and done pulses mid-cycle.
    always @(negedge clock) begin
        if (request)  req_count++;
        if (cpu_done) done_count++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_request"},   32'(request),   32'h0);
        check_val({tag, "_address"},   address,        32'h0);
        check_val({tag, "_write"},     32'(write),     32'h0);
        check_val({tag, "_wstrb"},     32'(wstrb),     32'h0);
        check_val({tag, "_wdata"},     wdata,          32'h0);
        check_val({tag, "_busy"},      32'(cpu_busy),  32'h0);
        check_val({tag, "_done"},      32'(cpu_done),  32'h0);
        check_val({tag, "_error"},     32'(cpu_error), 32'h0);
        check_val({tag, "_rdata"},     cpu_rdata,      32'h0);
    endtask

    // ---------------- reference model ----------------
    function automatic bit model_legal(input logic [1:0] sz, input logic [31:0] a);
        if (sz == 2'd0) return 1'b1;
        if (sz == 2'd1) return (a % 2) == 0;
        if (sz == 2'd2) return (a % 4) == 0;
        return 1'b0;
    endfunction

    function automatic logic [3:0] model_strb(input logic wr, input logic [1:0] sz, input logic [31:0] a);
        if (!wr) return 4'd0;
        if (sz == 2'd0) return 4'(1 << (a % 4));
        if (sz == 2'd1) return ((a % 4) == 2) ? 4'd12 : 4'd3;
        return 4'd15;
    endfunction

    function automatic logic [31:0] model_wdata(input logic [1:0] sz, input logic [31:0] d);
        if (sz == 2'd0) return (d % 256) * 32'h0101_0101;
        if (sz == 2'd1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] model_load(input logic [1:0] sz, input logic uns,
                                               input logic [31:0] a, input logic [31:0] rd);
        longint unsigned lane;
        int bits;
        bits = (sz == 2'd0) ? 8 : (sz == 2'd1) ? 16 : 32;
        lane = (64'(rd) >> (8 * (a % 4))) % (64'd1 << bits);
        if (!uns && bits < 32 && lane >= (64'd1 << (bits - 1)))
            lane = lane + (64'd1 << 32) - (64'd1 << bits);
        return lane[31:0];
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Offer one op in the current (IDLE) cycle and follow it to completion.
    // dly = extra cycles before ack; noise = junk ack/cpu_valid where ignored.
    task automatic do_op(input logic wr, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] d,
                         input int dly, input logic [31:0] rd, input bit noise);
        bit legal;
        int req_before;
        logic [31:0] exp_rdata;
        legal      = model_legal(sz, a);
        exp_rdata  = wr ? 32'h0 : model_load(sz, uns, a, rd);
        req_before = req_count;
        $display("op wr=%0d size=%0d uns=%0d addr=%h wdata=%h dly=%0d rdata=%h noise=%0d legal=%0d",
                 wr, sz, uns, a, d, dly, rd, noise, legal);
        cpu_valid = 1'b1; cpu_write = wr; cpu_size = sz; cpu_unsigned = uns;
        cpu_addr = a; cpu_wdata = d;
        tick();                                   // cycle N+1
        cpu_valid = 1'b0; cpu_addr = $urandom; cpu_wdata = $urandom;
        cpu_size = 2'($urandom); cpu_write = 1'($urandom);
        if (!legal) begin
            check_val("err_done",  32'(cpu_done),  32'h1);
            check_val("err_error", 32'(cpu_error), 32'h1);
            check_val("err_req",   32'(request),   32'h0);
            check_val("err_rdata", cpu_rdata,      32'h0);
            check_val("err_busy",  32'(cpu_busy),  32'h1);
        end else begin
            check_val("req_request", 32'(request),  32'h1);
            check_val("req_address", address,       a);
            check_val("req_write",   32'(write),    32'(wr));
            check_val("req_wstrb",   32'(wstrb),    32'(model_strb(wr, sz, a)));
            if (wr) check_val("req_wdata", wdata, model_wdata(sz, d));
            check_val("req_done",    32'(cpu_done), 32'h0);
            check_val("req_busy",    32'(cpu_busy), 32'h1);
            if (noise) begin ack = 1'b1; rdata = $urandom; end
            tick();                               // cycle N+2
            ack = 1'b0;
            for (int i = 0; i < dly; i++) begin
                check_val("wait_done", 32'(cpu_done), 32'h0);
                check_val("wait_busy", 32'(cpu_busy), 32'h1);
                if (noise) begin
                    cpu_valid = 1'($urandom); cpu_addr = $urandom & 32'hFFFF_FFFC;
                    cpu_size = 2'($urandom_range(0, 2)); cpu_write = 1'($urandom);
                end
                tick();
            end
            cpu_valid = 1'b0;
            ack = 1'b1; rdata = rd;
            tick();                               // DONE cycle
            ack = noise ? 1'b1 : 1'b0; rdata = $urandom;
            check_val("done_done",    32'(cpu_done),  32'h1);
            check_val("done_error",   32'(cpu_error), 32'h0);
            check_val("done_rdata",   cpu_rdata,      exp_rdata);
            check_val("done_address", address,        a);
            check_val("done_wstrb",   32'(wstrb),     32'(model_strb(wr, sz, a)));
        end
        tick();                                   // back in IDLE
        ack = 1'b0;
        check_val("idle_done", 32'(cpu_done), 32'h0);
        check_val("idle_busy", 32'(cpu_busy), 32'h0);
        check_val("req_pulses", 32'(req_count - req_before), legal ? 32'd1 : 32'd0);
    endtask

    initial begin
        reset = 1'b1; cpu_valid = 1'b0; cpu_write = 1'b0; cpu_size = 2'b00;
        cpu_unsigned = 1'b0; cpu_addr = 32'h0; cpu_wdata = 32'h0;
        rdata = 32'h0; ack = 1'b0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Directed cases
        do_op(1'b1, 2'b00, 1'b0, 32'h0000_1003, 32'h0000_00AB, 0, 32'h0, 1'b0);
        do_op(1'b0, 2'b01, 1'b0, 32'h0000_0002, 32'h0, 0, 32'h8001_1234, 1'b0);
        do_op(1'b0, 2'b01, 1'b1, 32'h0000_0002, 32'h0, 0, 32'h8001_1234, 1'b0);
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_0001, 32'h0, 0, 32'h0, 1'b0);
        do_op(1'b0, 2'b11, 1'b0, 32'h0000_0000, 32'h0, 0, 32'h0, 1'b0);
        do_op(1'b0, 2'b10, 1'b0, 32'h0000_0010, 32'h0, 5, 32'hCAFE_F00D, 1'b1);
        do_op(1'b0, 2'b00, 1'b0, 32'h0000_0003, 32'h0, 1, 32'h80FF_FFFF, 1'b0);
        do_op(1'b1, 2'b01, 1'b0, 32'h0000_0102, 32'h1234_BEEF, 2, 32'h0, 1'b0);

        // Reset while in WAIT after a long stall, ack arrives the next cycle
        begin
            int dc;
            cpu_valid = 1'b1; cpu_write = 1'b0; cpu_size = 2'b10;
            cpu_unsigned = 1'b0; cpu_addr = 32'h0000_0040;
            tick();
            cpu_valid = 1'b0;
            tick();                               // WAIT
            dc = done_count;
            repeat (40) tick();
            check_val("stall_busy", 32'(cpu_busy), 32'h1);
            check_val("stall_no_done", 32'(done_count - dc), 32'h0);
            reset = 1'b1;
            tick();
            reset = 1'b0; ack = 1'b1; rdata = 32'h1234_5678;
            check_all_zero("rst_wait");
            tick();
            ack = 1'b0;
            tick();
            check_all_zero("post_rst");
            check_val("post_rst_no_done", 32'(done_count - dc), 32'h0);
            $display("reset-in-WAIT sequence complete");
        end
        do_op(1'b0, 2'b00, 1'b1, 32'h0000_0041, 32'h0, 0, 32'h0000_9900, 1'b0);

`ifdef LSU_TIMEOUT_EN
        begin
            int cyc;
            int dc;
            cpu_valid = 1'b1; cpu_write = 1'b0; cpu_size = 2'b10;
            cpu_unsigned = 1'b0; cpu_addr = 32'h0000_0080;
            cyc = 0;
            tick(); cyc++;
            cpu_valid = 1'b0;
            while (!cpu_done && cyc < 400) begin
                tick(); cyc++;
            end
            check_val("to_cycle", 32'(cyc), 32'd258);
            check_val("to_error", 32'(cpu_error), 32'h1);
            check_val("to_rdata", cpu_rdata, 32'h0);
            dc = done_count;
            while (cyc < 300) begin tick(); cyc++; end
            ack = 1'b1; rdata = 32'hDEAD_BEEF;
            tick();
            ack = 1'b0;
            repeat (4) tick();
            check_val("late_ack_no_done", 32'(done_count - dc), 32'h0);
            check_val("late_ack_busy", 32'(cpu_busy), 32'h0);
            $display("timeout sequence complete at cycle offset %0d", cyc);
        end
`endif

        // Randomized ops
        for (int n = 0; n < 200; n++) begin
            logic [1:0]  sz;
            logic [31:0] a;
            sz = ($urandom_range(0, 7) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            a  = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a = a & 32'hFFFF_FFFE;
                if (sz == 2'b10) a = a & 32'hFFFF_FFFC;
            end
            do_op(1'($urandom), sz, 1'($urandom), a, $urandom,
                  $urandom_range(0, 4), $urandom, bit'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
